// File: rtl/jtag_fifo_pkg.sv
// Shared types and helpers for the JTAG single-clock FIFO and its storage.
package jtag_fifo_pkg;

  localparam bit MODE_STD  = 1'b0;
  localparam bit MODE_FWFT = 1'b1;

  // One extra pointer bit distinguishes full from empty when the addresses match.
  function automatic int ptr_width(input int depth_width);
    return depth_width + 1;
  endfunction

  // Accepted operations this cycle, encoded {write, read}.
  typedef enum logic [1:0] {
    OP_IDLE  = 2'b00,
    OP_RD    = 2'b01,
    OP_WR    = 2'b10,
    OP_WR_RD = 2'b11
  } fifo_op_e;

endpackage

// File: rtl/jtag_fifo_sdp_ram.sv
// Simple dual-port RAM: one write port, one registered read port, single clock.
module jtag_fifo_sdp_ram #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

  // NOTE: the array and its read register carry no reset so they map onto block RAM;
  // validity is tracked by the pointers and flags in the parent.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/jtag_sync_fifo_fwft.sv
// Single-clock FIFO for JTAG shift paths: standard or first-word-fall-through read,
// runtime almost thresholds, sticky overflow/underflow and exact occupancy.
module jtag_sync_fifo_fwft
  import jtag_fifo_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH_WIDTH = 10,
  parameter int FWFT        = 0,
  parameter int AF_DEFAULT  = (2**DEPTH_WIDTH) - 4,
  parameter int AE_DEFAULT  = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   wr_en,
  input  logic [DATA_WIDTH-1:0]  wr_data,
  output logic                   full,
  output logic                   almost_full,
  input  logic                   rd_en,
  output logic [DATA_WIDTH-1:0]  rd_data,
  output logic                   rd_valid,
  output logic                   empty,
  output logic                   almost_empty,
  input  logic [DEPTH_WIDTH:0]   af_thresh,
  input  logic [DEPTH_WIDTH:0]   ae_thresh,
  input  logic                   thresh_ld,
  output logic [DEPTH_WIDTH:0]   level,
  output logic                   overflow,
  output logic                   underflow,
  input  logic                   flag_clr
);

  localparam int PTR_W   = ptr_width(DEPTH_WIDTH);
  localparam bit IS_FWFT = (FWFT != 0) ? MODE_FWFT : MODE_STD;

  typedef logic [PTR_W-1:0] ptr_t;
  typedef logic [PTR_W-1:0] level_t;

  localparam level_t DEPTH_LVL = level_t'(2**DEPTH_WIDTH);

  ptr_t                  wr_ptr, rd_ptr;
  level_t                level_q, level_nxt;
  level_t                af_thr_q, ae_thr_q;
  logic                  af_q, ae_q, ovf_q, udf_q;
  logic                  valid_q, loaded_q;
  logic                  ptr_full, ram_empty;
  logic                  full_c, empty_c, ram_rd;
  logic                  wr_acc, rd_acc;
  logic [DATA_WIDTH-1:0] ram_q;
  fifo_op_e              op;

  assign ram_empty = (wr_ptr == rd_ptr);
  assign ptr_full  = (wr_ptr[PTR_W-2:0] == rd_ptr[PTR_W-2:0]) &&
                     (wr_ptr[PTR_W-1] != rd_ptr[PTR_W-1]);

  // In FWFT mode the output word counts toward capacity, so fullness follows the total
  // level and emptiness follows the output register rather than the RAM pointers.
  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    full_c  = ptr_full;
    empty_c = ram_empty;
    ram_rd  = 1'b0;
    if (IS_FWFT) begin
      full_c  = ptr_full | (level_q == DEPTH_LVL);
      empty_c = ~valid_q;
    end
    wr_acc = wr_en & ~full_c;
    rd_acc = rd_en & ~empty_c;
    if (IS_FWFT) ram_rd = ~ram_empty & (~valid_q | rd_en);
    else         ram_rd = rd_acc;
  end

  assign op = fifo_op_e'({wr_acc, rd_acc});

  always_comb begin
    level_nxt = level_q;
    case (op)
      OP_WR:   level_nxt = level_q + level_t'(1);
      OP_RD:   level_nxt = level_q - level_t'(1);
      default: level_nxt = level_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level_q  <= '0;
      af_thr_q <= level_t'(AF_DEFAULT);
      ae_thr_q <= level_t'(AE_DEFAULT);
      af_q     <= 1'b0;
      ae_q     <= 1'b1;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
      valid_q  <= 1'b0;
      loaded_q <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + ptr_t'(1);
      if (ram_rd) rd_ptr <= rd_ptr + ptr_t'(1);
      level_q <= level_nxt;
      if (thresh_ld) begin
        af_thr_q <= af_thresh;
        ae_thr_q <= ae_thresh;
      end
      af_q <= (level_nxt >= af_thr_q);
      ae_q <= (level_nxt <= ae_thr_q);
      // Clear wins over a same-cycle set.
      if (flag_clr)            ovf_q <= 1'b0;
      else if (wr_en & full_c) ovf_q <= 1'b1;
      if (flag_clr)             udf_q <= 1'b0;
      else if (rd_en & empty_c) udf_q <= 1'b1;
      if (IS_FWFT) begin
        if (ram_rd)      valid_q <= 1'b1;
        else if (rd_acc) valid_q <= 1'b0;
      end else begin
        valid_q <= rd_acc;
      end
      loaded_q <= loaded_q | ram_rd;
    end
  end

  jtag_fifo_sdp_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (DEPTH_WIDTH)
  ) u_ram (
    .clk     (clk),
    .wr_en   (wr_acc),
    .wr_addr (wr_ptr[PTR_W-2:0]),
    .wr_data (wr_data),
    .rd_en   (ram_rd),
    .rd_addr (rd_ptr[PTR_W-2:0]),
    .rd_data (ram_q)
  );

  // The RAM read register is unreset; mask it until a word has actually been read out.
  assign rd_data      = loaded_q ? ram_q : '0;
  assign rd_valid     = valid_q;
  assign full         = full_c;
  assign empty        = empty_c;
  assign almost_full  = af_q;
  assign almost_empty = ae_q;
  assign level        = level_q;
  assign overflow     = ovf_q;
  assign underflow    = udf_q;

endmodule
